// File: rtl/ap_wall_cpa_pipe_if.sv
// ap_wall_cpa_pipe_if: row-pair input and product output handshake bundle of the CPA stage
interface ap_wall_cpa_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             cout, ovf_sticky, ovf_clr;
  logic [WIDTH-1:0] row_s, row_c, prod;
  modport master (output in_valid, row_s, row_c, out_ready, ovf_clr,
                  input  in_ready, out_valid, prod, cout, ovf_sticky);
  modport slave  (input  in_valid, row_s, row_c, out_ready, ovf_clr,
                  output in_ready, out_valid, prod, cout, ovf_sticky);
endinterface

// File: rtl/ap_wall_cpa_pipe.sv
// ap_wall_cpa_pipe: two-stage carry-propagate adder for the approximate Wallace rows, split at LO_W; AP_CPA_SAT_EN saturates on carry-out
module ap_wall_cpa_pipe #(
  parameter int WIDTH = 16,
  parameter int LO_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ap_wall_cpa_pipe_if.slave   bus
);
  localparam int HI_W = WIDTH - LO_W;

  logic             r_v1, r_c1, r_v2, r_cout, r_ovf;
  logic [LO_W-1:0]  r_lo1;
  logic [HI_W-1:0]  r_s_hi, r_c_hi;
  logic [WIDTH-1:0] r_prod;
  logic             w_ready1, w_ready2;
  logic [LO_W:0]    w_lo_sum;
  logic [HI_W:0]    w_hi_sum;
  logic [WIDTH-1:0] w_prod;

  assign w_ready2 = !r_v2 || bus.out_ready;
  assign w_ready1 = !r_v1 || w_ready2;
  assign w_lo_sum = {1'b0, bus.row_s[LO_W-1:0]} + {1'b0, bus.row_c[LO_W-1:0]};
  assign w_hi_sum = {1'b0, r_s_hi} + {1'b0, r_c_hi} + {{HI_W{1'b0}}, r_c1};
`ifdef AP_CPA_SAT_EN
  assign w_prod = w_hi_sum[HI_W] ? '1 : {w_hi_sum[HI_W-1:0], r_lo1};
`else
  assign w_prod = {w_hi_sum[HI_W-1:0], r_lo1};
`endif

  assign bus.in_ready   = w_ready1;
  assign bus.out_valid  = r_v2;
  assign bus.prod       = r_prod;
  assign bus.cout       = r_cout;
  assign bus.ovf_sticky = r_ovf;

  // Stage 1: low-half add plus pass-through of the upper row slices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_c1   <= 1'b0;
      r_lo1  <= '0;
      r_s_hi <= '0;
      r_c_hi <= '0;
    end else if (w_ready1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        {r_c1, r_lo1} <= w_lo_sum;
        r_s_hi        <= bus.row_s[WIDTH-1:LO_W];
        r_c_hi        <= bus.row_c[WIDTH-1:LO_W];
      end
    end
  end

  // Stage 2: high-half add with the stage-1 carry, held until the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_prod <= '0;
      r_cout <= 1'b0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod <= w_prod;
        r_cout <= w_hi_sum[HI_W];
      end
    end
  end

  // Sticky overflow: set by a delivered result with carry-out, clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (bus.ovf_clr) r_ovf <= 1'b0;
    else if (r_v2 && bus.out_ready && r_cout) r_ovf <= 1'b1;
  end
endmodule

// File: doc/ap_wall_cpa_pipe.md
Name: ap_wall_cpa_pipe

Overview:
- Final carry-propagate stage of the approximate unsigned Wallace multiplier (8x8, 16-bit product).
- Consumes the two reduced rows (sum row, carry row) produced by the approximate-compressor tree.
- Adds the rows in a two-stage pipeline split at a configurable bit position, with valid/ready handshakes on both sides.
- Delivers the registered product to the multiplier output or error-evaluation logic.

Parameters:
- WIDTH, 16, row and product width in bits.
- LO_W, 8, width of the low-half adder in stage 1; legal range 1..WIDTH-1; high half is WIDTH-LO_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  row pair on row_s/row_c is valid.
- in_ready  out  1  block accepts the row pair this cycle.
- row_s  in  WIDTH  sum row from the compressor tree.
- row_c  in  WIDTH  carry row from the compressor tree, already weight-aligned to row_s.
- out_valid  out  1  prod is valid.
- out_ready  in  1  downstream accepts prod this cycle.
- prod  out  WIDTH  final product.
- cout  out  1  carry out of bit WIDTH-1 for the current prod.
- ovf_sticky  out  1  set when any delivered result had cout=1.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous, active-low. While rst_n=0, every valid bit, prod, cout and ovf_sticky are 0.
  - in_ready follows its combinational equation, so it reads 1 while both stages are empty.
  - Reset mid-operation discards all in-flight data; nothing is replayed.
- Stage 1 register (v1):
  - On accept (in_valid && in_ready): store {c1, lo1} = row_s[LO_W-1:0] + row_c[LO_W-1:0] (LO_W+1 bits).
  - Also store row_s[WIDTH-1:LO_W] and row_c[WIDTH-1:LO_W] unmodified.
- Stage 2 / output register (v2 = out_valid):
  - {cout, hi} = s_hi + c_hi + c1 (WIDTH-LO_W+1 bits).
  - prod = {hi, lo1}.
- Advance rules:
  - ready2 = !v2 || out_ready.
  - ready1 = !v1 || ready2.
  - in_ready = ready1, combinational from out_ready and the valid bits; no combinational path from in_valid to in_ready.
  - A stage loads when its upstream is valid and the stage is ready. Otherwise a valid stage holds its data and clears only when drained.
- Latency and throughput:
  - A row pair accepted in cycle N appears with out_valid=1 in cycle N+2, if not stalled.
  - Sustained throughput is 1 result per cycle with out_ready held at 1.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0, and prod/cout hold stable until the handshake.
  - At most 2 items are in flight; no data is lost or duplicated.
- Arithmetic: unsigned. Without the optional feature, results wrap modulo 2^WIDTH.
- ovf_sticky:
  - Set in the cycle after an output handshake with cout=1.
  - ovf_clr in the same cycle as a set has priority (result 0).
- Handshake protocol rules:
  - Once out_valid=1, prod and cout must not change until out_ready=1.
  - The upstream must hold row_s/row_c stable while in_valid=1 and in_ready=0.

Optional Feature:
- Macro AP_CPA_SAT_EN.
- Defined: when the stage-2 sum has cout=1, prod is forced to all ones (0xFFFF at default WIDTH). cout and ovf_sticky still report the carry.
- Undefined: prod is the wrapped sum, modulo 2^WIDTH.
- Latency and handshake are identical in both builds.

Test Plan:
- Carry across the split: row_s=0x00FF, row_c=0x0001, out_ready=1 → prod=0x0100, cout=0, out_valid exactly 2 cycles after accept.
- Overflow: row_s=0xFFFF, row_c=0x0001 → cout=1; prod=0x0000 without AP_CPA_SAT_EN, 0xFFFF with it; ovf_sticky=1 on the next cycle; pulse ovf_clr → 0.
- Streaming: 10 back-to-back pairs (row_s=k*0x0101, row_c=0x0011), out_ready=1 → 10 consecutive out_valid cycles, each prod=row_s+row_c, in order.
- Backpressure: out_ready=0 while 3 pairs are offered → exactly 2 accepted, in_ready=0 on the third; prod held stable; out_ready=1 → all 3 delivered in order, none dropped.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 items in flight → out_valid, prod, cout, ovf_sticky go to 0 immediately; after release, in_ready=1 and the next pair yields a correct result.
- Parameter sweep: LO_W=1 and LO_W=15 → 1000 random pairs match the (row_s+row_c) reference model, with cout equal to bit 16.
